// File: rtl/kalman_pkg.sv
// Shared types and default sizing for the gyro-integration predict step.
package kalman_pkg;

  localparam int DEF_WIDTH = 16;
  localparam int DEF_DT_W  = 8;
  localparam int DEF_NCH   = 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MULT = 2'd1,
    ADD  = 2'd2,
    DONE = 2'd3
  } state_t;

endpackage

// File: rtl/kalman_sat_add.sv
// Signed add of a WIDTH-bit angle and a (WIDTH+2)-bit increment, clamped to WIDTH bits.
module kalman_sat_add #(
  parameter int WIDTH = 16
) (
  input  logic signed [WIDTH-1:0] a,
  input  logic signed [WIDTH+1:0] b,
  output logic signed [WIDTH-1:0] sum,
  output logic                    sat
);

  logic signed [WIDTH+2:0] full;
  logic [3:0]              top_bits;
  logic                    in_range;

  assign full     = (WIDTH+3)'(a) + (WIDTH+3)'(b);
  assign top_bits = full[WIDTH+2:WIDTH-1];
  // The result fits only when every bit above the target sign bit copies it.
  assign in_range = (&top_bits) | ~(|top_bits);

  always_comb begin
    sum = full[WIDTH-1:0];
    sat = 1'b0;
    if (!in_range) begin
      sat = 1'b1;
      if (full[WIDTH+2]) sum = {1'b1, {(WIDTH-1){1'b0}}};
      else               sum = {1'b0, {(WIDTH-1){1'b1}}};
    end
  end

endmodule

// File: rtl/kalman_predict.sv
// Multi-channel angle predictor: angle[ch] += (rate - bias) * dt, saturating,
// with a four-state request/response handshake and a direct load path.
module kalman_predict
  import kalman_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int DT_W  = DEF_DT_W,
  parameter int NCH   = DEF_NCH,
  localparam int CH_W = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic             clk,
  input  logic             n_rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [CH_W-1:0]  in_ch,
  input  logic [WIDTH-1:0] rate_in,
  input  logic [WIDTH-1:0] bias_in,
  input  logic [DT_W-1:0]  dt_in,
  input  logic             load_en,
  input  logic [CH_W-1:0]  load_ch,
  input  logic [WIDTH-1:0] load_angle,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [CH_W-1:0]  out_ch,
  output logic [WIDTH-1:0] out_angle,
  output logic             out_sat,
  output logic             out_err
);

  localparam int PW = WIDTH + DT_W + 2;
  localparam logic [CH_W:0] NCH_LIM = (CH_W+1)'(NCH);

  state_t state_reg, state_next;

  logic [CH_W-1:0]         ch_reg;
  logic [WIDTH-1:0]        rate_reg;
  logic [WIDTH-1:0]        bias_reg;
  logic [DT_W-1:0]         dt_reg;
  logic                    err_reg;
  logic signed [WIDTH+1:0] dt_angle_reg;
  logic signed [WIDTH-1:0] angle_reg [NCH];

  logic [CH_W-1:0]  out_ch_reg;
  logic [WIDTH-1:0] out_angle_reg;
  logic             out_sat_reg;
  logic             out_err_reg;

  logic                    accept;
  logic signed [WIDTH:0]   rate_tc;
  logic signed [WIDTH:0]   corr_rate;
  logic signed [PW-1:0]    corr_ext;
  logic signed [PW-1:0]    dt_ext;
  logic signed [PW-1:0]    product;
  logic signed [WIDTH-1:0] angle_cur;
  logic signed [WIDTH-1:0] sat_sum;
  logic                    sat_flag;

  assign in_ready  = (state_reg == IDLE) && !load_en;
  assign accept    = in_valid && in_ready;
  assign out_valid = (state_reg == DONE);
  assign out_ch    = out_ch_reg;
  assign out_angle = out_angle_reg;
  assign out_sat   = out_sat_reg;
  assign out_err   = out_err_reg;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) state_reg <= IDLE;
    else        state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (accept) state_next = MULT;
      MULT:    state_next = ADD;
      ADD:     state_next = DONE;
      DONE:    if (out_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Sign-magnitude to two's complement; a negative zero collapses to zero.
  always_comb begin
    rate_tc = $signed({1'b0, 1'b0, rate_reg[WIDTH-2:0]});
    if (rate_reg[WIDTH-1]) rate_tc = -rate_tc;
  end

  assign corr_rate = rate_tc - $signed({bias_reg[WIDTH-1], bias_reg});
  assign corr_ext  = PW'(corr_rate);
  assign dt_ext    = PW'({1'b0, dt_reg});
  assign product   = corr_ext * dt_ext;

  always_comb begin
    angle_cur = '0;
    for (int i = 0; i < NCH; i++) begin
      if (ch_reg == CH_W'(i)) angle_cur = angle_reg[i];
    end
  end

  kalman_sat_add #(
    .WIDTH(WIDTH)
  ) u_sat_add (
    .a  (angle_cur),
    .b  (dt_angle_reg),
    .sum(sat_sum),
    .sat(sat_flag)
  );

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      ch_reg        <= '0;
      rate_reg      <= '0;
      bias_reg      <= '0;
      dt_reg        <= '0;
      err_reg       <= 1'b0;
      dt_angle_reg  <= '0;
      out_ch_reg    <= '0;
      out_angle_reg <= '0;
      out_sat_reg   <= 1'b0;
      out_err_reg   <= 1'b0;
    end else begin
      if (accept) begin
        ch_reg   <= in_ch;
        rate_reg <= rate_in;
        bias_reg <= bias_in;
        dt_reg   <= dt_in;
        err_reg  <= ({1'b0, in_ch} >= NCH_LIM);
      end
      // Dropping the low DT_W bits is the arithmetic shift (floor rounding).
      if (state_reg == MULT) dt_angle_reg <= product[PW-1:DT_W];
      if (state_reg == ADD) begin
        out_ch_reg    <= ch_reg;
        out_err_reg   <= err_reg;
        out_angle_reg <= err_reg ? '0 : sat_sum;
        out_sat_reg   <= err_reg ? 1'b0 : sat_flag;
      end
    end
  end

  // One register per channel; loads only land in IDLE so they never meet an ADD write.
  genvar gi;
  generate
    for (gi = 0; gi < NCH; gi++) begin : g_angle
      always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
          angle_reg[gi] <= '0;
        end else if ((state_reg == IDLE) && load_en && (load_ch == CH_W'(gi))) begin
          angle_reg[gi] <= load_angle;
        end else if ((state_reg == ADD) && !err_reg && (ch_reg == CH_W'(gi))) begin
          angle_reg[gi] <= sat_sum;
        end
      end
    end
  endgenerate

endmodule
